alu_nibble_seq: RTL and testbench

- Multi-cycle controller that performs 4*NIBBLES-bit ALU operations on one shared 4-bit ALU (alu_4bit).
- It feeds the ALU one nibble per cycle, least-significant nibble first, and chains the carry between nibbles through a register.
- It sits between a requester (start/done handshake) and a combinational alu_4bit instance in the parent.

---
 rtl/alu_nibble_seq.sv | 106 ++++++++++
 tb/tb_alu_nibble_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// Runs 4*NIBBLES-bit add/sub/AND/OR on one external 4-bit ALU, LS nibble first; done NIBBLES+1 cycles after start.
// No backpressure: start is taken only in IDLE and dropped (not queued) while busy.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic [1:0]             opcode,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [1:0]             alu_op,
  output logic                   alu_cin,
  input  logic [3:0]             alu_result,
  input  logic                   alu_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [1:0]      op_q;
  logic [IW-1:0]   idx;
  logic            carry_q;
  logic            last;
  logic            arith;
  logic [W-1:0]    a_sh, b_sh;

  assign last  = (idx == IW'(NIBBLES - 1));
  // Only add/sub use the carry chain; bitwise ops force carry to 0.
  assign arith = ~op_q[1];
  assign a_sh  = a_q >> {idx, 2'b00};
  assign b_sh  = b_q >> {idx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_op  = 2'b00;
    alu_cin = 1'b0;
    case (state)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        alu_a   = a_sh[3:0];
        alu_b   = b_sh[3:0];
        alu_op  = op_q;
        alu_cin = arith & carry_q;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      idx     <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        a_q     <= a;
        b_q     <= b;
        op_q    <= opcode;
        idx     <= '0;
        result  <= '0;
        busy    <= 1'b1;
        // Subtract is a + ~b + 1: the +1 enters as the first carry-in.
        carry_q <= (opcode == 2'b01);
      end
    end else begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (idx == IW'(k)) result[4*k +: 4] <= alu_result;
      end
      carry_q <= arith & alu_cout;
      idx     <= idx + IW'(1);
      if (last) begin
        cout <= arith & alu_cout;
        busy <= 1'b0;
        done <= 1'b1;
        idx  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq (NIBBLES=4) with a behavioural 4-bit ALU.
module tb_alu_nibble_seq;

  localparam int NIBBLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic [1:0]  opcode;
  logic        busy, done, cout;
  logic [15:0] result;
  logic [3:0]  alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        alu_cin, alu_cout;

  int n_tests = 0;
  int n_fail  = 0;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .opcode(opcode),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 00 a+b+cin, 01 a+~b+cin, 10 AND, 11 OR (cout 0).
  logic [4:0] sum;
  always_comb begin
    sum        = {1'b0, alu_a} + {1'b0, (alu_op == 2'b01) ? ~alu_b : alu_b} + {4'b0, alu_cin};
    alu_result = sum[3:0];
    alu_cout   = sum[4];
    if (alu_op == 2'b10) begin
      alu_result = alu_a & alu_b;
      alu_cout   = 1'b0;
    end else if (alu_op == 2'b11) begin
      alu_result = alu_a | alu_b;
      alu_cout   = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [1:0] iop, input logic [15:0] er, input logic ec,
                        input logic [15:0] ea_seq, input logic [3:0] ecin_seq);
    logic [15:0] seq;
    logic [3:0]  cs;
    int          nb, nd;
    @(negedge clk);
    a = ia; b = ib; opcode = iop; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; opcode = 2'b11;
    seq = '0; cs = '0; nb = 0; nd = 0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (i > 0) @(negedge clk);
      seq = {seq[11:0], alu_a};
      cs  = {cs[2:0], alu_cin};
      nb += int'(busy);
      nd += int'(done);
    end
    check({tag, "_busy_cycles"}, nb, NIBBLES);
    check({tag, "_early_done"}, nd, 0);
    check({tag, "_alu_a_seq"}, seq, ea_seq);
    check({tag, "_cin_seq"}, cs, ecin_seq);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_alu_idle"}, {alu_a, alu_b, alu_op, alu_cin}, 0);
    @(negedge clk);
    check({tag, "_done_fall"}, done, 0);
    check({tag, "_result_hold"}, {cout, result}, {ec, er});
  endtask

  initial begin
    int  i;
    int  nd;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; opcode = 2'b00;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("add1", 16'h1234, 16'h0FFF, 2'b00, 16'h2233, 1'b0, 16'h4321, 4'b0111);
    run_op("add2", 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 16'hFFFF, 4'b0111);
    run_op("sub1", 16'h1000, 16'h0001, 2'b01, 16'h0FFF, 1'b1, 16'h0001, 4'b1000);
    run_op("sub2", 16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b0, 16'h0000, 4'b1000);
    run_op("and",  16'hA5A5, 16'h0FF0, 2'b10, 16'h05A0, 1'b0, 16'h5A5A, 4'b0000);
    run_op("or",   16'hA5A5, 16'h0FF0, 2'b11, 16'hAFF5, 1'b0, 16'h5A5A, 4'b0000);

    // Start while busy is ignored; start in the done cycle is taken.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; opcode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; opcode = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_ignored", busy, 1);
    for (i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_done_cycle", i, 1);
    check("b2b_result", result, 16'h0002);
    check("b2b_cout", cout, 0);
    a = 16'hFFFF; b = 16'h0002; opcode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_done", done, 0);
    for (i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b2_done_cycle", i, 3);
    check("b2b2_result", result, 16'h0001);
    check("b2b2_cout", cout, 1);

    // Reset while idx = 2.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; opcode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_alu_a", alu_a, 4'h1);
    check("mid_partial", result, 16'h0033);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_cout", cout, 0);
    check("arst_result", result, 0);
    check("arst_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
    nd = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nd += int'(done);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nd += int'(done) + int'(busy);
    end
    check("arst_no_done", nd, 0);
    run_op("post_rst", 16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0, 16'h3000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
